vx_warp_drain_ctrl: RTL and testbench

VX_WARP_DRAIN_CTRL -- requirements
Module: VX_warp_drain_ctrl

---
 rtl/vx_warp_drain_ctrl_pkg.sv | 16 +
 rtl/vx_commit_sched_if.sv | 9 +
 rtl/vx_warp_drain_ctrl_rr_arbiter.sv | 54 +++++
 rtl/vx_warp_drain_ctrl.sv | 112 +++++++++++
 tb/tb_vx_warp_drain_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_warp_drain_ctrl_pkg.sv
// Shared types and helpers for the warp drain controller.
package vx_warp_drain_ctrl_pkg;

    localparam int DEFAULT_NUM_WARPS = 4;

    typedef enum logic [1:0] {
        WS_IDLE  = 2'd0,
        WS_DRAIN = 2'd1,
        WS_DONE  = 2'd2
    } warp_state_e;

    function automatic int nw_width(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

endpackage

// File: rtl/vx_commit_sched_if.sv
// Commit-to-scheduler path: one commit pulse per warp per cycle.
interface vx_commit_sched_if #(
    parameter int NUM_WARPS = vx_warp_drain_ctrl_pkg::DEFAULT_NUM_WARPS
);
    logic [NUM_WARPS-1:0] committed_warps;

    modport master (output committed_warps);
    modport slave  (input  committed_warps);
endinterface

// File: rtl/vx_warp_drain_ctrl_rr_arbiter.sv
// Round-robin arbiter whose grant is frozen while a presented grant waits for acceptance.
module vx_warp_drain_ctrl_rr_arbiter #(
    parameter  int NUM_REQS = 4,
    localparam int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                grant_ready,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_index
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] held_idx_q;
    logic             held_q;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        pick  = ptr_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQS);
            if (!found && requests[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A newly arriving requester must not steal a grant already on offer.
    assign grant_valid = |requests;
    assign grant_index = held_q ? held_idx_q : pick;

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            held_q     <= 1'b0;
            held_idx_q <= '0;
        end else begin
            held_q     <= grant_valid && !grant_ready;
            held_idx_q <= grant_index;
            if (grant_valid && grant_ready) begin
                ptr_q <= (grant_index == IDX_W'(NUM_REQS - 1)) ? '0 : grant_index + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/vx_warp_drain_ctrl.sv
// Tracks in-flight instructions per warp and sequences fence/tmc/barrier drains.
module vx_warp_drain_ctrl
    import vx_warp_drain_ctrl_pkg::*;
#(
    parameter  int NUM_WARPS   = DEFAULT_NUM_WARPS,
    parameter  int MAX_PENDING = 4,
    parameter  int CNT_W       = $clog2(MAX_PENDING + 1),
    localparam int NW_WIDTH    = nw_width(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [NW_WIDTH-1:0]  issue_wid,
    output logic                 issue_ready,
    vx_commit_sched_if.slave     commit_sched_if,
    input  logic                 drain_req_valid,
    input  logic [NW_WIDTH-1:0]  drain_req_wid,
    output logic                 drain_req_ready,
    output logic                 drain_done_valid,
    output logic [NW_WIDTH-1:0]  drain_done_wid,
    input  logic                 drain_done_ready,
    output logic [NUM_WARPS-1:0] stall_warps,
    output logic [NUM_WARPS-1:0] pending_empty
);

    warp_state_e          state_q [NUM_WARPS];
    warp_state_e          state_d [NUM_WARPS];
    logic [CNT_W-1:0]     count_q [NUM_WARPS];
    logic [CNT_W-1:0]     count_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] issue_fire_w;
    logic [NUM_WARPS-1:0] drain_fire_w;
    logic [NUM_WARPS-1:0] underflow;
    logic [NUM_WARPS-1:0] done_req;
    logic                 done_fire;

    always_comb begin
        issue_fire_w = '0;
        drain_fire_w = '0;
        if (issue_valid && issue_ready)         issue_fire_w[issue_wid]     = 1'b1;
        if (drain_req_valid && drain_req_ready) drain_fire_w[drain_req_wid] = 1'b1;
    end

    // Issue and commit in the same cycle cancel; a commit at zero saturates.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            count_d[w]   = count_q[w];
            underflow[w] = 1'b0;
            case ({issue_fire_w[w], commit_sched_if.committed_warps[w]})
                2'b10: count_d[w] = count_q[w] + CNT_W'(1);
                2'b01: begin
                    if (count_q[w] == '0) underflow[w] = 1'b1;
                    else                  count_d[w]   = count_q[w] - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // NOTE: the counters and states are plain flops, not a RAM, so every entry is reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= '0;
                state_q[w] <= WS_IDLE;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                count_q[w] <= count_d[w];
                state_q[w] <= state_d[w];
            end
        end
    end

    // DRAIN looks at the registered count, so a same-cycle issue is counted first.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            state_d[w] = state_q[w];
            case (state_q[w])
                WS_IDLE:  if (drain_fire_w[w]) state_d[w] = WS_DRAIN;
                WS_DRAIN: if (count_q[w] == '0) state_d[w] = WS_DONE;
                WS_DONE:  if (done_fire && (drain_done_wid == NW_WIDTH'(w))) state_d[w] = WS_IDLE;
                default:  state_d[w] = WS_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            stall_warps[w]   = (state_q[w] != WS_IDLE) || (count_q[w] == CNT_W'(MAX_PENDING));
            pending_empty[w] = (count_q[w] == '0);
            done_req[w]      = (state_q[w] == WS_DONE);
        end
        issue_ready     = !stall_warps[issue_wid];
        drain_req_ready = (state_q[drain_req_wid] == WS_IDLE);
    end

    assign done_fire = drain_done_valid && drain_done_ready;

    vx_warp_drain_ctrl_rr_arbiter #(
        .NUM_REQS (NUM_WARPS)
    ) done_arb (
        .clk         (clk),
        .reset       (reset),
        .requests    (done_req),
        .grant_ready (drain_done_ready),
        .grant_valid (drain_done_valid),
        .grant_index (drain_done_wid)
    );

    commit_underflow_a: assert property (@(posedge clk) disable iff (reset) underflow == '0);

endmodule

// File: tb/tb_vx_warp_drain_ctrl.sv
// Randomized and directed bench for vx_warp_drain_ctrl against a behavioural model.
module tb_vx_warp_drain_ctrl;

    localparam int NW  = 4;
    localparam int MAX = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [1:0]    issue_wid;
    logic          issue_ready;
    logic          drain_req_valid;
    logic [1:0]    drain_req_wid;
    logic          drain_req_ready;
    logic          drain_done_valid;
    logic [1:0]    drain_done_wid;
    logic          drain_done_ready;
    logic [NW-1:0] stall_warps;
    logic [NW-1:0] pending_empty;

    vx_commit_sched_if #(.NUM_WARPS(NW)) commit_if ();

    vx_warp_drain_ctrl #(.NUM_WARPS(NW), .MAX_PENDING(MAX)) dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_wid        (issue_wid),
        .issue_ready      (issue_ready),
        .commit_sched_if  (commit_if),
        .drain_req_valid  (drain_req_valid),
        .drain_req_wid    (drain_req_wid),
        .drain_req_ready  (drain_req_ready),
        .drain_done_valid (drain_done_valid),
        .drain_done_wid   (drain_done_wid),
        .drain_done_ready (drain_done_ready),
        .stall_warps      (stall_warps),
        .pending_empty    (pending_empty)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Model: pending count per warp, a set of draining warps, a set of drained warps
    // awaiting report, the round-robin start point and the grant on offer last cycle.
    int m_cnt      [NW] = '{default: 0};
    bit m_draining [NW] = '{default: 1'b0};
    bit m_done     [NW] = '{default: 1'b0};
    int m_rr   = 0;
    bit m_hold = 1'b0;
    int m_held = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_outputs(output logic [NW-1:0] e_stall, output logic [NW-1:0] e_empty,
                                          output logic e_irdy, output logic e_drdy,
                                          output logic e_dv, output logic [1:0] e_dw);
        bit found;
        found  = 1'b0;
        e_dv   = 1'b0;
        e_dw   = 2'd0;
        for (int w = 0; w < NW; w++) begin
            e_stall[w] = m_draining[w] || m_done[w] || (m_cnt[w] == MAX);
            e_empty[w] = (m_cnt[w] == 0);
            if (m_done[w]) e_dv = 1'b1;
        end
        e_irdy = !e_stall[issue_wid];
        e_drdy = !m_draining[drain_req_wid] && !m_done[drain_req_wid];
        if (m_hold) begin
            e_dw = 2'(m_held);
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (!found && m_done[(m_rr + k) % NW]) begin
                    found = 1'b1;
                    e_dw  = 2'((m_rr + k) % NW);
                end
            end
        end
    endfunction

    always @(posedge clk) begin : model_update
        logic [NW-1:0] e_stall, e_empty;
        logic          e_irdy, e_drdy, e_dv;
        logic [1:0]    e_dw;
        int            old_cnt [NW];
        bit            inc, dec;
        if (reset) begin
            for (int w = 0; w < NW; w++) begin
                m_cnt[w] = 0;
                m_draining[w] = 1'b0;
                m_done[w] = 1'b0;
            end
            m_rr = 0;
            m_hold = 1'b0;
            m_held = 0;
        end else begin
            model_outputs(e_stall, e_empty, e_irdy, e_drdy, e_dv, e_dw);
            for (int w = 0; w < NW; w++) old_cnt[w] = m_cnt[w];
            for (int w = 0; w < NW; w++) begin
                inc = issue_valid && e_irdy && (int'(issue_wid) == w);
                dec = commit_if.committed_warps[w];
                if (inc && !dec) m_cnt[w]++;
                else if (dec && !inc && m_cnt[w] > 0) m_cnt[w]--;
                if (m_draining[w] && old_cnt[w] == 0) begin
                    m_draining[w] = 1'b0;
                    m_done[w] = 1'b1;
                end
            end
            if (drain_req_valid && e_drdy) m_draining[drain_req_wid] = 1'b1;
            if (e_dv && drain_done_ready) begin
                m_done[e_dw] = 1'b0;
                m_rr = (int'(e_dw) + 1) % NW;
            end
            m_hold = e_dv && !drain_done_ready;
            m_held = int'(e_dw);
        end
    end

    always @(negedge clk) begin : compare
        logic [NW-1:0] e_stall, e_empty;
        logic          e_irdy, e_drdy, e_dv;
        logic [1:0]    e_dw;
        #2;
        if (check_en) begin
            model_outputs(e_stall, e_empty, e_irdy, e_drdy, e_dv, e_dw);
            check("stall_warps", 32'(stall_warps), 32'(e_stall));
            check("pending_empty", 32'(pending_empty), 32'(e_empty));
            check("issue_ready", 32'(issue_ready), 32'(e_irdy));
            check("drain_req_ready", 32'(drain_req_ready), 32'(e_drdy));
            check("drain_done_valid", 32'(drain_done_valid), 32'(e_dv));
            if (e_dv) check("drain_done_wid", 32'(drain_done_wid), 32'(e_dw));
        end
    end

    task automatic drive_idle();
        reset = 1'b0;
        issue_valid = 1'b0;
        issue_wid = 2'd0;
        commit_if.committed_warps = '0;
        drain_req_valid = 1'b0;
        drain_req_wid = 2'd0;
        drain_done_ready = 1'b1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        drive_idle();
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic issue_on(input int w);
        issue_valid = 1'b1;
        issue_wid = 2'(w);
    endtask

    task automatic drain_on(input int w);
        drain_req_valid = 1'b1;
        drain_req_wid = 2'(w);
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        check_en = 1'b1;

        // Reset values.
        next_cycle(); settle();
        check("rst_stall", 32'(stall_warps), 32'h0);
        check("rst_empty", 32'(pending_empty), 32'hf);
        check("rst_done_valid", 32'(drain_done_valid), 32'h0);
        check("rst_drain_ready", 32'(drain_req_ready), 32'h1);
        check("rst_issue_ready", 32'(issue_ready), 32'h1);

        // Fill warp 1 to the limit, then try a fourth issue.
        for (int i = 0; i < 3; i++) begin
            next_cycle(); issue_on(1);
        end
        next_cycle(); issue_on(1); settle();
        check("full_issue_ready", 32'(issue_ready), 32'h0);
        check("full_stall", 32'(stall_warps), 32'h2);
        check("full_empty", 32'(pending_empty), 32'hd);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); commit_if.committed_warps = 4'b0010;
        end
        next_cycle(); settle();
        check("w1_cleared", 32'(pending_empty), 32'hf);

        // Same-cycle issue and commit at count 1.
        next_cycle(); issue_on(0);
        next_cycle(); issue_on(0); commit_if.committed_warps = 4'b0001;
        next_cycle(); settle();
        check("issue_commit_empty", 32'(pending_empty), 32'he);
        commit_if.committed_warps = 4'b0001;
        next_cycle();

        // Drain warp 2 with two instructions outstanding.
        next_cycle(); issue_on(2);
        next_cycle(); issue_on(2);
        next_cycle(); drain_on(2); settle();
        check("w2_drain_ready", 32'(drain_req_ready), 32'h1);
        next_cycle(); commit_if.committed_warps = 4'b0100; settle();
        check("w2_stall_t1", 32'(stall_warps), 32'h4);
        next_cycle(); commit_if.committed_warps = 4'b0100;
        next_cycle(); settle();
        check("w2_not_done_t3", 32'(drain_done_valid), 32'h0);
        next_cycle(); settle();
        check("w2_done_valid_t4", 32'(drain_done_valid), 32'h1);
        check("w2_done_wid_t4", 32'(drain_done_wid), 32'h2);
        next_cycle(); settle();
        check("w2_released", 32'(stall_warps), 32'h0);

        // Two warps drained at count 0, report held back for five cycles.
        next_cycle(); drain_done_ready = 1'b0; drain_on(0);
        next_cycle(); drain_done_ready = 1'b0; drain_on(3);
        for (int i = 0; i < 5; i++) begin
            next_cycle(); drain_done_ready = 1'b0; settle();
            check("hold_valid", 32'(drain_done_valid), 32'h1);
            check("hold_wid", 32'(drain_done_wid), 32'h0);
        end
        next_cycle(); settle();
        check("release_first", 32'(drain_done_wid), 32'h0);
        next_cycle(); settle();
        check("release_second_valid", 32'(drain_done_valid), 32'h1);
        check("release_second", 32'(drain_done_wid), 32'h3);
        next_cycle(); settle();
        check("release_idle", 32'(drain_done_valid), 32'h0);

        // Reset in the middle of a drain.
        next_cycle(); issue_on(1);
        next_cycle(); issue_on(1);
        next_cycle(); drain_on(1);
        next_cycle(); reset = 1'b1;
        next_cycle(); settle();
        check("abort_stall", 32'(stall_warps), 32'h0);
        check("abort_empty", 32'(pending_empty), 32'hf);
        check("abort_issue_ready", 32'(issue_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); settle();
            check("abort_no_done", 32'(drain_done_valid), 32'h0);
        end

        // Drain request for a warp already draining.
        next_cycle(); issue_on(3);
        next_cycle(); drain_on(3);
        next_cycle(); drain_on(3); settle();
        check("redrain_ready", 32'(drain_req_ready), 32'h0);
        check("redrain_stall", 32'(stall_warps), 32'h8);
        next_cycle(); commit_if.committed_warps = 4'b1000;
        next_cycle(); settle();
        check("redrain_t3_no_done", 32'(drain_done_valid), 32'h0);
        next_cycle(); settle();
        check("redrain_done_wid", 32'(drain_done_wid), 32'h3);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            reset = ($urandom_range(0, 249) == 0);
            issue_valid = ($urandom_range(0, 2) != 0);
            issue_wid = 2'($urandom_range(0, NW - 1));
            for (int w = 0; w < NW; w++)
                commit_if.committed_warps[w] = (m_cnt[w] > 0) && ($urandom_range(0, 2) == 0);
            drain_req_valid = ($urandom_range(0, 3) == 0);
            drain_req_wid = 2'($urandom_range(0, NW - 1));
            drain_done_ready = ($urandom_range(0, 2) != 0);
        end

        next_cycle();
        next_cycle();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
